// File: rtl/flash_read_cache.sv
// flash_read_cache: direct-mapped read-only word cache in front of MappedSPIFlash.
// Optional saturating hit/miss counters are built when FLASH_CACHE_STATS_EN is defined.
module flash_read_cache #(
  parameter int LINES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rstrb,
  input  logic [19:0] word_address,
  output logic [31:0] rdata,
  output logic        rbusy,
  input  logic        invalidate,
  output logic        flash_rstrb,
  output logic [19:0] flash_word_address,
  input  logic [31:0] flash_rdata,
  input  logic        flash_rbusy,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);
  localparam int INDEX_BITS = $clog2(LINES);
  localparam int TAG_BITS = 20 - INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    FILL
  } state_t;

  state_t state_q, state_d;

  logic [19:0]           addr_q;
  logic [31:0]           rdata_q;
  logic [LINES-1:0]      valid_q;
  logic [TAG_BITS-1:0]   tag_mem [LINES];
  logic [31:0]           data_mem [LINES];

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;
  logic                  hit;
  logic                  capture;
  logic                  lookup_hit;
  logic                  fill_done;

  assign idx = addr_q[INDEX_BITS-1:0];
  assign tag = addr_q[19:INDEX_BITS];
  assign hit = valid_q[idx] && (tag_mem[idx] == tag);
  assign flash_word_address = addr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rbusy       = 1'b0;
    flash_rstrb = 1'b0;
    capture     = 1'b0;
    lookup_hit  = 1'b0;
    fill_done   = 1'b0;
    rdata       = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (rstrb) begin
          capture = 1'b1;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          lookup_hit = 1'b1;
          rdata      = data_mem[idx];
          if (rstrb) begin
            capture = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          rbusy       = 1'b1;
          flash_rstrb = 1'b1;
          state_d     = FILL;
        end
      end
      FILL: begin
        rbusy = flash_rbusy;
        if (!flash_rbusy) begin
          fill_done = 1'b1;
          rdata     = flash_rdata;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      rdata_q <= '0;
    end else begin
      if (capture) begin
        addr_q <= word_address;
      end
      if (lookup_hit) begin
        rdata_q <= data_mem[idx];
      end else if (fill_done) begin
        rdata_q <= flash_rdata;
      end
    end
  end

  // invalidate wins over a fill completing on the same edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else if (invalidate) begin
      valid_q <= '0;
    end else if (fill_done) begin
      valid_q[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= flash_rdata;
    end
  end

`ifdef FLASH_CACHE_STATS_EN
  logic [15:0] hit_q;
  logic [15:0] miss_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (invalidate) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      if (lookup_hit && hit_q != 16'hFFFF) begin
        hit_q <= hit_q + 16'd1;
      end
      if (flash_rstrb && miss_q != 16'hFFFF) begin
        miss_q <= miss_q + 16'd1;
      end
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_flash_read_cache.sv
// tb_flash_read_cache: directed checks of flash_read_cache with an
// 8-cycle-latency flash model.
module tb_flash_read_cache;
`ifdef FLASH_CACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rstrb = 1'b0;
  logic        invalidate = 1'b0;
  logic [19:0] word_address = '0;
  logic [31:0] rdata;
  logic        rbusy;
  logic        flash_rstrb;
  logic [19:0] flash_word_address;
  logic [31:0] flash_rdata = 32'h0BAD0BAD;
  logic        flash_rbusy = 1'b0;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int vecs = 0;
  int errs = 0;
  int fl_cnt = 0;
  int fl_strobes = 0;
  logic [19:0] fl_addr = '0;

  flash_read_cache #(.LINES(64)) dut (
    .clk(clk),
    .reset(reset),
    .rstrb(rstrb),
    .word_address(word_address),
    .rdata(rdata),
    .rbusy(rbusy),
    .invalidate(invalidate),
    .flash_rstrb(flash_rstrb),
    .flash_word_address(flash_word_address),
    .flash_rdata(flash_rdata),
    .flash_rbusy(flash_rbusy),
    .hit_count(hit_count),
    .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fdata(input logic [19:0] a);
    case (a)
      20'h00010: return 32'hDEADBEEF;
      20'h00050: return 32'hCAFEF00D;
      20'h00011: return 32'h12345678;
      default:   return {12'hA5A, a};
    endcase
  endfunction

  function automatic logic [15:0] ec(input int n);
    return STATS ? 16'(n) : 16'd0;
  endfunction

  // Flash: busy from the cycle after the strobe, data 8 cycles after it
  always @(negedge clk) begin
    if (reset) begin
      fl_cnt = 0;
      flash_rbusy = 1'b0;
    end else begin
      if (fl_cnt > 0) begin
        fl_cnt = fl_cnt - 1;
        if (fl_cnt == 0) begin
          flash_rbusy = 1'b0;
          flash_rdata = fdata(fl_addr);
        end
      end
      if (flash_rstrb) begin
        fl_strobes = fl_strobes + 1;
        fl_addr = flash_word_address;
        fl_cnt = 7;
        flash_rbusy = 1'b1;
        flash_rdata = 32'h0BAD0BAD;
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // lat counts cycles from strobe to the first cycle with rbusy low
  task automatic do_read(input logic [19:0] a, input int inv_k,
                         output int lat, output logic [31:0] d,
                         output int strobes, output logic [19:0] fa);
    int s0;
    s0 = fl_strobes;
    word_address = a;
    rstrb = 1'b1;
    step();
    rstrb = 1'b0;
    lat = 1;
    while (rbusy === 1'b1 && lat < 40) begin
      invalidate = (lat == inv_k);
      step();
      lat++;
    end
    invalidate = 1'b0;
    d = rdata;
    strobes = fl_strobes - s0;
    fa = fl_addr;
  endtask

  task automatic pulse_reset;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) step();
    vecs++; if (rdata !== 32'h0) begin errs++; $display("FAIL rst_rdata: got %h want 0", rdata); end
    vecs++; if (rbusy !== 1'b0) begin errs++; $display("FAIL rst_rbusy: got %b want 0", rbusy); end
    vecs++; if (flash_rstrb !== 1'b0) begin errs++; $display("FAIL rst_fstrb: got %b want 0", flash_rstrb); end
    vecs++; if (flash_word_address !== 20'h0) begin errs++; $display("FAIL rst_faddr: got %h want 0", flash_word_address); end
    vecs++; if (hit_count !== 16'h0) begin errs++; $display("FAIL rst_hits: got %0d want 0", hit_count); end
    vecs++; if (miss_count !== 16'h0) begin errs++; $display("FAIL rst_misses: got %0d want 0", miss_count); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_cold_miss;
    int lat, st;
    logic [31:0] d;
    logic [19:0] fa;
    do_read(20'h00010, 0, lat, d, st, fa);
    vecs++; if (lat != 9) begin errs++; $display("FAIL cold_lat: got %0d want 9", lat); end
    vecs++; if (d !== 32'hDEADBEEF) begin errs++; $display("FAIL cold_data: got %h want deadbeef", d); end
    vecs++; if (st != 1) begin errs++; $display("FAIL cold_strobes: got %0d want 1", st); end
    vecs++; if (fa !== 20'h00010) begin errs++; $display("FAIL cold_faddr: got %h want 00010", fa); end
    vecs++; if (miss_count !== ec(1)) begin errs++; $display("FAIL cold_misses: got %0d want %0d", miss_count, ec(1)); end
  endtask

  task automatic test_hit;
    int lat, st;
    logic [31:0] d;
    logic [19:0] fa;
    do_read(20'h00010, 0, lat, d, st, fa);
    vecs++; if (lat != 1) begin errs++; $display("FAIL hit_lat: got %0d want 1", lat); end
    vecs++; if (d !== 32'hDEADBEEF) begin errs++; $display("FAIL hit_data: got %h want deadbeef", d); end
    step();
    vecs++; if (st != 0 || fl_strobes != 1) begin errs++; $display("FAIL hit_strobes: got %0d want 0", st); end
    vecs++; if (hit_count !== ec(1)) begin errs++; $display("FAIL hit_count: got %0d want %0d", hit_count, ec(1)); end
  endtask

  task automatic test_conflict;
    int lat, st;
    logic [31:0] d;
    logic [19:0] fa;
    logic [19:0] seq [3];
    seq[0] = 20'h00010;
    seq[1] = 20'h00050;
    seq[2] = 20'h00010;
    pulse_reset();
    foreach (seq[i]) begin
      do_read(seq[i], 0, lat, d, st, fa);
      vecs++; if (lat != 9) begin errs++; $display("FAIL conflict_lat%0d: got %0d want 9", i, lat); end
      vecs++; if (d !== fdata(seq[i])) begin errs++; $display("FAIL conflict_data%0d: got %h want %h", i, d, fdata(seq[i])); end
    end
    vecs++; if (miss_count !== ec(3)) begin errs++; $display("FAIL conflict_misses: got %0d want %0d", miss_count, ec(3)); end
    vecs++; if (hit_count !== 16'h0) begin errs++; $display("FAIL conflict_hits: got %0d want 0", hit_count); end
  endtask

  task automatic test_invalidate;
    int lat, st;
    logic [31:0] d;
    logic [19:0] fa;
    do_read(20'h00050, 0, lat, d, st, fa);
    invalidate = 1'b1;
    step();
    invalidate = 1'b0;
    vecs++; if (miss_count !== 16'h0) begin errs++; $display("FAIL inv_clr_misses: got %0d want 0", miss_count); end
    vecs++; if (hit_count !== 16'h0) begin errs++; $display("FAIL inv_clr_hits: got %0d want 0", hit_count); end
    do_read(20'h00050, 0, lat, d, st, fa);
    vecs++; if (lat != 9) begin errs++; $display("FAIL inv_lat: got %0d want 9", lat); end
    vecs++; if (d !== 32'hCAFEF00D) begin errs++; $display("FAIL inv_data: got %h want cafef00d", d); end
    vecs++; if (miss_count !== ec(1)) begin errs++; $display("FAIL inv_misses: got %0d want %0d", miss_count, ec(1)); end
    do_read(20'h00011, 8, lat, d, st, fa);
    vecs++; if (lat != 9) begin errs++; $display("FAIL inv_edge_lat: got %0d want 9", lat); end
    vecs++; if (d !== 32'h12345678) begin errs++; $display("FAIL inv_edge_data: got %h want 12345678", d); end
    do_read(20'h00011, 0, lat, d, st, fa);
    vecs++; if (lat != 9) begin errs++; $display("FAIL inv_edge_reread: got %0d want 9", lat); end
    vecs++; if (miss_count !== ec(1)) begin errs++; $display("FAIL inv_edge_misses: got %0d want %0d", miss_count, ec(1)); end
  endtask

  task automatic test_reset_mid_fill;
    int lat, st;
    logic [31:0] d;
    logic [19:0] fa;
    do_read(20'h00010, 0, lat, d, st, fa);
    word_address = 20'h00013;
    rstrb = 1'b1;
    step();
    rstrb = 1'b0;
    repeat (3) step();
    #2 reset = 1'b1;
    #1;
    vecs++; if (rbusy !== 1'b0) begin errs++; $display("FAIL mid_rbusy: got %b want 0", rbusy); end
    vecs++; if (rdata !== 32'h0) begin errs++; $display("FAIL mid_rdata: got %h want 0", rdata); end
    vecs++; if (flash_rstrb !== 1'b0) begin errs++; $display("FAIL mid_fstrb: got %b want 0", flash_rstrb); end
    vecs++; if (flash_word_address !== 20'h0) begin errs++; $display("FAIL mid_faddr: got %h want 0", flash_word_address); end
    vecs++; if (miss_count !== 16'h0) begin errs++; $display("FAIL mid_misses: got %0d want 0", miss_count); end
    step();
    step();
    reset = 1'b0;
    step();
    do_read(20'h00010, 0, lat, d, st, fa);
    vecs++; if (lat != 9) begin errs++; $display("FAIL mid_reread_lat: got %0d want 9", lat); end
    vecs++; if (d !== 32'hDEADBEEF) begin errs++; $display("FAIL mid_reread_data: got %h want deadbeef", d); end
  endtask

  task automatic test_back_to_back;
    int lat, st, s0;
    logic [31:0] d;
    logic [19:0] fa;
    logic busy_seen;
    pulse_reset();
    do_read(20'h00010, 0, lat, d, st, fa);
    do_read(20'h00011, 0, lat, d, st, fa);
    s0 = fl_strobes;
    word_address = 20'h00010;
    rstrb = 1'b1;
    step();
    busy_seen = rbusy;
    vecs++; if (rdata !== 32'hDEADBEEF) begin errs++; $display("FAIL b2b_data0: got %h want deadbeef", rdata); end
    word_address = 20'h00011;
    step();
    rstrb = 1'b0;
    busy_seen = busy_seen | rbusy;
    vecs++; if (rdata !== 32'h12345678) begin errs++; $display("FAIL b2b_data1: got %h want 12345678", rdata); end
    vecs++; if (busy_seen !== 1'b0) begin errs++; $display("FAIL b2b_rbusy: got %b want 0", busy_seen); end
    step();
    vecs++; if (hit_count !== ec(2)) begin errs++; $display("FAIL b2b_hits: got %0d want %0d", hit_count, ec(2)); end
    vecs++; if (fl_strobes != s0) begin errs++; $display("FAIL b2b_strobes: got %0d want %0d", fl_strobes, s0); end
    vecs++; if (rdata !== 32'h12345678) begin errs++; $display("FAIL b2b_hold: got %h want 12345678", rdata); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_invalidate();
    test_reset_mid_fill();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
